axi_llc_refill_r_master: RTL and testbench

// - AR/R manager of the LLC refill path; read-side counterpart of the eviction AW/W/B path.
// - Accepts one refill descriptor at a time and issues one INCR AR burst for the whole cache line.
// - Writes every R beat into the selected data way.
// - Forwards the descriptor to the next pipeline stage, with an error flag, once the line is complete.

---
 rtl/axi_llc_refill_r_master.sv | 192 +++++++++++++++++++
 tb/tb_axi_llc_refill_r_master.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_llc_refill_r_master.sv
// ============================================================================
//  Module   : axi_llc_refill_r_master
//  Purpose  : AR/R manager of the LLC refill path. Accepts one refill
//             descriptor, issues a single INCR AR burst covering the whole
//             cache line, writes every R beat into the selected data way and
//             forwards the descriptor (with an error flag) downstream.
//  Options  : AXI_LLC_REFILL_ID_CHECK_EN - flag R beats whose ID != ArId.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_llc_refill_r_master #(
    parameter int unsigned IdWidth      = 4,
    parameter int unsigned AddrWidth    = 32,
    parameter int unsigned DataWidth    = 64,
    parameter int unsigned NumWays      = 8,
    parameter int unsigned BeatsPerLine = 8,
    parameter int unsigned ArId         = 0,
    localparam int unsigned WayIdxW     = $clog2(NumWays),
    localparam int unsigned BeatW       = $clog2(BeatsPerLine)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    // Descriptor input
    input  logic [AddrWidth-1:0] desc_addr_i,
    input  logic [WayIdxW-1:0]   desc_way_i,
    input  logic                 desc_refill_i,
    input  logic                 desc_valid_i,
    output logic                 desc_ready_o,
    // Descriptor output
    output logic [AddrWidth-1:0] desc_addr_o,
    output logic [WayIdxW-1:0]   desc_way_o,
    output logic                 desc_err_o,
    output logic                 desc_valid_o,
    input  logic                 desc_ready_i,
    // AXI AR channel
    output logic [IdWidth-1:0]   ar_id_o,
    output logic [AddrWidth-1:0] ar_addr_o,
    output logic [7:0]           ar_len_o,
    output logic [2:0]           ar_size_o,
    output logic [1:0]           ar_burst_o,
    output logic                 ar_valid_o,
    input  logic                 ar_ready_i,
    // AXI R channel
    input  logic [IdWidth-1:0]   r_id_i,
    input  logic [DataWidth-1:0] r_data_i,
    input  logic [1:0]           r_resp_i,
    input  logic                 r_last_i,
    input  logic                 r_valid_i,
    output logic                 r_ready_o,
    // Data way write port
    output logic [NumWays-1:0]   way_sel_o,
    output logic [BeatW-1:0]     way_beat_o,
    output logic [DataWidth-1:0] way_data_o,
    output logic                 way_valid_o,
    input  logic                 way_ready_i
);

    // Byte offset bits of a cache line; zeroed to form the burst start address.
    localparam int unsigned c_OFF_W = $clog2(BeatsPerLine * DataWidth / 8);

    localparam logic [AddrWidth-1:0] c_LINE_MASK = ~((AddrWidth'(1) << c_OFF_W) - AddrWidth'(1));
    localparam logic [BeatW-1:0]     c_LAST_BEAT = BeatW'(BeatsPerLine - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND_AR   = 2'd1,
        ST_RECV_R    = 2'd2,
        ST_SEND_DESC = 2'd3
    } state_t;

    state_t                r_state;
    logic [AddrWidth-1:0]  r_addr;
    logic [WayIdxW-1:0]    r_way;
    logic [BeatW-1:0]      r_beat;
    logic                  r_err;

    logic                  w_r_hs;
    logic                  w_last_beat;
    logic                  w_id_err;
    logic                  w_beat_err;

    assign w_r_hs      = (r_state == ST_RECV_R) && r_valid_i && way_ready_i;
    assign w_last_beat = (r_beat == c_LAST_BEAT);

`ifdef AXI_LLC_REFILL_ID_CHECK_EN
    assign w_id_err = (r_id_i != IdWidth'(ArId));
`else
    // Without the ID check the R ID is intentionally ignored.
    logic w_unused_id;
    assign w_unused_id = ^r_id_i;
    assign w_id_err    = 1'b0;
`endif

    // r_resp_i[0] (EXOKAY/DECERR distinction) carries no meaning here.
    logic w_unused_resp;
    assign w_unused_resp = r_resp_i[0];

    // The line length comes from the counter; r_last only cross-checks it.
    assign w_beat_err = r_resp_i[1] | (r_last_i != w_last_beat) | w_id_err;

    // Control FSM: descriptor accept, AR issue, beat counting, descriptor hand-off.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_way   <= '0;
            r_beat  <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (desc_valid_i) begin
                        r_addr  <= desc_addr_i;
                        r_way   <= desc_way_i;
                        r_err   <= 1'b0;
                        r_state <= desc_refill_i ? ST_SEND_AR : ST_SEND_DESC;
                    end
                end
                ST_SEND_AR: begin
                    if (ar_ready_i) begin
                        r_state <= ST_RECV_R;
                    end
                end
                ST_RECV_R: begin
                    if (w_r_hs) begin
                        r_err <= r_err | w_beat_err;
                        if (w_last_beat) begin
                            r_beat  <= '0;
                            r_state <= ST_SEND_DESC;
                        end else begin
                            r_beat <= r_beat + BeatW'(1);
                        end
                    end
                end
                ST_SEND_DESC: begin
                    if (desc_ready_i) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Output decode; everything is forced low while reset is asserted.
    always_comb begin
        desc_ready_o = 1'b0;
        desc_valid_o = 1'b0;
        desc_addr_o  = '0;
        desc_way_o   = '0;
        desc_err_o   = 1'b0;
        ar_valid_o   = 1'b0;
        ar_id_o      = '0;
        ar_addr_o    = '0;
        ar_len_o     = '0;
        ar_size_o    = '0;
        ar_burst_o   = '0;
        r_ready_o    = 1'b0;
        way_valid_o  = 1'b0;
        way_sel_o    = '0;
        way_beat_o   = '0;
        way_data_o   = '0;
        if (!rst_i) begin
            desc_ready_o = (r_state == ST_IDLE);
            desc_valid_o = (r_state == ST_SEND_DESC);
            desc_addr_o  = r_addr;
            desc_way_o   = r_way;
            desc_err_o   = r_err;
            if (r_state == ST_SEND_AR) begin
                ar_valid_o = 1'b1;
                ar_id_o    = IdWidth'(ArId);
                ar_addr_o  = r_addr & c_LINE_MASK;
                ar_len_o   = 8'(BeatsPerLine - 1);
                ar_size_o  = 3'($clog2(DataWidth / 8));
                ar_burst_o = 2'b01;
            end
            if (r_state == ST_RECV_R) begin
                r_ready_o   = way_ready_i;
                way_valid_o = r_valid_i;
                if (r_valid_i) begin
                    way_sel_o  = NumWays'(1) << r_way;
                    way_beat_o = r_beat;
                    way_data_o = r_data_i;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_axi_llc_refill_r_master.sv
// ============================================================================
//  Module   : tb_axi_llc_refill_r_master
//  Purpose  : Directed self-checking bench for axi_llc_refill_r_master.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi_llc_refill_r_master;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] desc_addr_i = '0;
    logic [2:0]  desc_way_i = '0;
    logic        desc_refill_i = 1'b0;
    logic        desc_valid_i = 1'b0;
    logic        desc_ready_o;
    logic [31:0] desc_addr_o;
    logic [2:0]  desc_way_o;
    logic        desc_err_o;
    logic        desc_valid_o;
    logic        desc_ready_i = 1'b0;
    logic [3:0]  ar_id_o;
    logic [31:0] ar_addr_o;
    logic [7:0]  ar_len_o;
    logic [2:0]  ar_size_o;
    logic [1:0]  ar_burst_o;
    logic        ar_valid_o;
    logic        ar_ready_i = 1'b0;
    logic [3:0]  r_id_i = '0;
    logic [63:0] r_data_i = '0;
    logic [1:0]  r_resp_i = '0;
    logic        r_last_i = 1'b0;
    logic        r_valid_i = 1'b0;
    logic        r_ready_o;
    logic [7:0]  way_sel_o;
    logic [2:0]  way_beat_o;
    logic [63:0] way_data_o;
    logic        way_valid_o;
    logic        way_ready_i = 1'b0;

    int n_pass  = 0;
    int n_total = 0;

`ifdef AXI_LLC_REFILL_ID_CHECK_EN
    localparam logic c_ID_ERR = 1'b1;
`else
    localparam logic c_ID_ERR = 1'b0;
`endif

    axi_llc_refill_r_master dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .desc_addr_i   (desc_addr_i),
        .desc_way_i    (desc_way_i),
        .desc_refill_i (desc_refill_i),
        .desc_valid_i  (desc_valid_i),
        .desc_ready_o  (desc_ready_o),
        .desc_addr_o   (desc_addr_o),
        .desc_way_o    (desc_way_o),
        .desc_err_o    (desc_err_o),
        .desc_valid_o  (desc_valid_o),
        .desc_ready_i  (desc_ready_i),
        .ar_id_o       (ar_id_o),
        .ar_addr_o     (ar_addr_o),
        .ar_len_o      (ar_len_o),
        .ar_size_o     (ar_size_o),
        .ar_burst_o    (ar_burst_o),
        .ar_valid_o    (ar_valid_o),
        .ar_ready_i    (ar_ready_i),
        .r_id_i        (r_id_i),
        .r_data_i      (r_data_i),
        .r_resp_i      (r_resp_i),
        .r_last_i      (r_last_i),
        .r_valid_i     (r_valid_i),
        .r_ready_o     (r_ready_o),
        .way_sel_o     (way_sel_o),
        .way_beat_o    (way_beat_o),
        .way_data_o    (way_data_o),
        .way_valid_o   (way_valid_o),
        .way_ready_i   (way_ready_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full refill transaction; rst_at >= 0 aborts with a reset on that beat.
    task automatic refill(input logic [31:0] addr, input logic [2:0] way,
                          input int ar_wait, input bit toggle, input int bad_resp_at,
                          input int last_at, input logic [3:0] id,
                          input logic exp_err, input int rst_at);
        logic [31:0] exp_ar_addr;
        int          beat;
        bit          t;
        exp_ar_addr   = {addr[31:6], 6'b0};
        desc_addr_i   = addr;
        desc_way_i    = way;
        desc_refill_i = 1'b1;
        desc_valid_i  = 1'b1;
        #1;
        chk("accept_ready", desc_ready_o, 1);
        step();
        desc_valid_i = 1'b0;
        #1;
        chk("ar_valid_latency", ar_valid_o, 1);
        chk("ar_addr", ar_addr_o, exp_ar_addr);
        chk("ar_len", ar_len_o, 7);
        chk("ar_size", ar_size_o, 3);
        chk("ar_burst", ar_burst_o, 1);
        chk("ar_id", ar_id_o, 0);
        chk("r_ready_in_ar", r_ready_o, 0);
        for (int i = 0; i < ar_wait; i++) begin
            step();
            chk("ar_hold_valid", ar_valid_o, 1);
            chk("ar_hold_addr", ar_addr_o, exp_ar_addr);
        end
        ar_ready_i = 1'b1;
        step();
        ar_ready_i = 1'b0;
        #1;
        chk("ar_dropped", ar_valid_o, 0);
        beat = 0;
        t    = 1'b0;
        while (beat < 8) begin
            r_valid_i   = 1'b1;
            r_data_i    = 64'(beat);
            r_resp_i    = (beat == bad_resp_at) ? 2'b10 : 2'b00;
            r_last_i    = (beat == last_at);
            r_id_i      = id;
            way_ready_i = toggle ? t : 1'b1;
            t           = ~t;
            if (beat == rst_at) begin
                rst_i = 1'b1;
                #1;
                chk("rst_way_valid", way_valid_o, 0);
                chk("rst_r_ready", r_ready_o, 0);
                chk("rst_desc_valid", desc_valid_o, 0);
                chk("rst_ar_valid", ar_valid_o, 0);
                chk("rst_desc_ready", desc_ready_o, 0);
                step();
                rst_i       = 1'b0;
                r_valid_i   = 1'b0;
                way_ready_i = 1'b0;
                #1;
                chk("post_rst_desc_ready", desc_ready_o, 1);
                chk("post_rst_way_valid", way_valid_o, 0);
                return;
            end
            #1;
            chk("way_valid", way_valid_o, 1);
            chk("r_ready_tracks", r_ready_o, way_ready_i);
            chk("way_beat", way_beat_o, beat);
            chk("way_sel", way_sel_o, 8'h01 << way);
            chk("way_data", way_data_o, beat);
            chk("desc_valid_early", desc_valid_o, 0);
            if (way_ready_i) beat++;
            step();
        end
        r_valid_i   = 1'b0;
        r_last_i    = 1'b0;
        way_ready_i = 1'b0;
        #1;
        chk("desc_valid_latency", desc_valid_o, 1);
        chk("desc_addr", desc_addr_o, addr);
        chk("desc_way", desc_way_o, way);
        chk("desc_err", desc_err_o, exp_err);
        chk("desc_ready_busy", desc_ready_o, 0);
        chk("way_valid_idle", way_valid_o, 0);
        step();
        chk("desc_hold_valid", desc_valid_o, 1);
        chk("desc_hold_addr", desc_addr_o, addr);
        desc_ready_i = 1'b1;
        step();
        desc_ready_i = 1'b0;
        #1;
        chk("desc_done_valid", desc_valid_o, 0);
        chk("desc_done_ready", desc_ready_o, 1);
    endtask

    initial begin
        // Reset state
        step();
        chk("reset_desc_ready", desc_ready_o, 0);
        chk("reset_desc_valid", desc_valid_o, 0);
        chk("reset_ar_valid", ar_valid_o, 0);
        chk("reset_way_valid", way_valid_o, 0);
        step();
        rst_i = 1'b0;
        #1;
        chk("idle_desc_ready", desc_ready_o, 1);
        chk("idle_ar_valid", ar_valid_o, 0);

        // Basic refill of way 3
        refill(32'h1000_0123, 3'd3, 0, 1'b0, -1, 7, 4'd0, 1'b0, -1);

        // Bypass descriptor: no AXI traffic
        desc_addr_i   = 32'hABCD_0040;
        desc_way_i    = 3'd5;
        desc_refill_i = 1'b0;
        desc_valid_i  = 1'b1;
        step();
        desc_valid_i = 1'b0;
        #1;
        chk("byp_desc_valid", desc_valid_o, 1);
        chk("byp_desc_addr", desc_addr_o, 32'hABCD_0040);
        chk("byp_desc_way", desc_way_o, 5);
        chk("byp_desc_err", desc_err_o, 0);
        for (int i = 0; i < 20; i++) begin
            chk("byp_no_ar", ar_valid_o, 0);
            step();
        end
        desc_ready_i = 1'b1;
        step();
        desc_ready_i = 1'b0;
        #1;
        chk("byp_done", desc_valid_o, 0);

        // Backpressure on AR and way write port
        refill(32'h2000_07C8, 3'd6, 5, 1'b1, -1, 7, 4'd0, 1'b0, -1);

        // SLVERR on beat 4
        refill(32'h3000_0000, 3'd0, 0, 1'b0, 4, 7, 4'd0, 1'b1, -1);

        // Early r_last on beat 5, none on beat 7; still 8 beats consumed
        refill(32'h4000_0040, 3'd7, 0, 1'b0, -1, 5, 4'd0, 1'b1, -1);

        // Reset during beat 3, then a clean refill
        refill(32'h5000_0100, 3'd1, 0, 1'b0, -1, 7, 4'd0, 1'b0, 3);
        refill(32'h5000_0100, 3'd2, 0, 1'b0, -1, 7, 4'd0, 1'b0, -1);

        // Wrong R ID on every beat
        refill(32'h6000_0080, 3'd4, 0, 1'b0, -1, 7, 4'd5, c_ID_ERR, -1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
